// File: rtl/ift_sram_init_pkg.sv
// Shared types for the taint-aware SRAM initiator.
// Response entry layout, FIFO depth and a control-taint helper.
package ift_sram_init_pkg;

  localparam int unsigned RspWidth  = 64;
  localparam int unsigned FifoDepth = 2;

  typedef struct packed {
    logic                write;
    logic [RspWidth-1:0] rdata;
    logic [RspWidth-1:0] rdata_taint;
  } rsp_entry_t;

  // Any taint on valid, write or address makes the whole response suspect
  function automatic logic ctrl_taint(
    input logic valid_t,
    input logic write_t,
    input logic addr_t_any
  );
    return valid_t | write_t | addr_t_any;
  endfunction

endpackage

// File: rtl/ift_sram_rsp_fifo.sv
// Two-entry response FIFO with simultaneous push/pop at any fill level.
// Head reads as zero when empty.
import ift_sram_init_pkg::*;

module ift_sram_rsp_fifo #(
  parameter type T = rsp_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  T           push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output logic [1:0] count_o,
  output T           head_o
);

  T           r_mem [FifoDepth];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_full;

  assign w_full  = (r_count == 2'd2);
  assign valid_o = (r_count != 2'd0);
  assign count_o = r_count;
  assign head_o  = valid_o ? r_mem[r_rptr] : '0;

  // Storage: a push when full overwrites the slot being popped this cycle
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= push_data_i;
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (push_i) r_wptr <= ~r_wptr;
      if (pop_i)  r_rptr <= ~r_rptr;
      if (push_i && !pop_i)      r_count <= r_count + 2'd1;
      else if (!push_i && pop_i) r_count <= r_count - 2'd1;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push_i && w_full && !pop_i)
  );

endmodule

// File: rtl/ift_sram_initiator.sv
// Taint-aware valid/ready requester for a single-port taint SRAM.
// Macro IFT_SRAM_INIT_STICKY_TAINT_EN enables the sticky taint flag.
import ift_sram_init_pkg::*;

module ift_sram_initiator #(
  parameter int unsigned Width     = 64,
  parameter int unsigned Aw        = 8,
  parameter int unsigned NumTaints = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  input  logic               req_valid_i_taint,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic               req_write_i_taint,
  input  logic [Aw-1:0]      req_addr_i,
  input  logic [Aw-1:0]      req_addr_i_taint,
  input  logic [Width-1:0]   req_wdata_i,
  input  logic [Width-1:0]   req_wdata_i_taint,
  input  logic [Width/8-1:0] req_wmask_i,
  input  logic [Width/8-1:0] req_wmask_i_taint,
  output logic               sram_req_o,
  output logic               sram_req_o_taint,
  output logic               sram_write_o,
  output logic               sram_write_o_taint,
  output logic [Aw-1:0]      sram_addr_o,
  output logic [Aw-1:0]      sram_addr_o_taint,
  output logic [Width-1:0]   sram_wdata_o,
  output logic [Width-1:0]   sram_wdata_o_taint,
  output logic [Width/8-1:0] sram_wmask_o,
  output logic [Width/8-1:0] sram_wmask_o_taint,
  input  logic [Width-1:0]   sram_rdata_i,
  input  logic [Width-1:0]   sram_rdata_i_taint,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_write_o,
  output logic [Width-1:0]   rsp_rdata_o,
  output logic [Width-1:0]   rsp_rdata_o_taint
);

  localparam int unsigned Mw = Width / 8;

  typedef struct packed {
    logic             write;
    logic [Width-1:0] rdata;
    logic [Width-1:0] rdata_taint;
  } entry_t;

  if (NumTaints != 1) begin : g_bad_taints
    $error("ift_sram_initiator supports NumTaints == 1 only");
  end
  if (Width % 8 != 0) begin : g_bad_width
    $error("ift_sram_initiator needs Width to be a multiple of 8");
  end

  logic       r_inflight;
  logic       r_wr;
  logic       r_ctrl_t;
  logic       w_sticky;
  logic       w_en;
  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_valid;
  logic       w_addr_t;
  logic [1:0] w_count;
  logic [2:0] w_occ;
  entry_t     w_head;
  entry_t     w_rsp;
  entry_t     w_new;

  assign w_en     = ~rst_i;
  assign w_addr_t = |req_addr_i_taint;

  assign w_rsp       = w_en ? w_head : '0;
  assign rsp_valid_o = w_valid & w_en;
  assign rsp_write_o = w_rsp.write;
  assign rsp_rdata_o = w_rsp.rdata;
  assign rsp_rdata_o_taint = w_rsp.rdata_taint;

  assign w_pop = rsp_valid_o & rsp_ready_i;
  // Credits: everything outstanding must fit in the two FIFO slots
  assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign req_ready_o = w_en & (w_occ < 3'd2);
  assign w_issue = req_valid_i & req_ready_o;

  assign sram_req_o         = w_issue;
  assign sram_write_o       = req_write_i & w_en;
  assign sram_addr_o        = req_addr_i & {Aw{w_en}};
  assign sram_wdata_o       = req_wdata_i & {Width{w_en}};
  assign sram_wmask_o       = req_wmask_i & {Mw{w_en}};
  assign sram_req_o_taint   = req_valid_i_taint & w_en;
  assign sram_write_o_taint = req_write_i_taint & w_en;
  assign sram_addr_o_taint  = req_addr_i_taint & {Aw{w_en}};
  assign sram_wdata_o_taint = req_wdata_i_taint & {Width{w_en}};
  assign sram_wmask_o_taint = req_wmask_i_taint & {Mw{w_en}};

  // Track the request whose read data arrives next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
      r_wr       <= 1'b0;
      r_ctrl_t   <= 1'b0;
    end else if (w_issue) begin
      r_inflight <= 1'b1;
      r_wr       <= req_write_i;
      r_ctrl_t   <= ctrl_taint(req_valid_i_taint,
                               req_write_i_taint, w_addr_t);
    end else begin
      r_inflight <= 1'b0;
    end
  end

`ifdef IFT_SRAM_INIT_STICKY_TAINT_EN
  logic r_sticky;

  // A tainted-address write may have hit any word; distrust all later data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sticky <= 1'b0;
    end else if (w_issue && req_write_i && w_addr_t &&
                 ((|(req_wmask_i | req_wmask_i_taint)) ||
                  req_write_i_taint)) begin
      r_sticky <= 1'b1;
    end
  end
  assign w_sticky = r_sticky;
`else
  assign w_sticky = 1'b0;
`endif

  assign w_push = r_inflight & w_en;
  assign w_new.write = r_wr;
  assign w_new.rdata = r_wr ? '0 : sram_rdata_i;
  assign w_new.rdata_taint = (r_wr ? '0 : sram_rdata_i_taint) |
                             {Width{r_ctrl_t | w_sticky}};

  ift_sram_rsp_fifo #(
    .T (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_new),
    .pop_i       (w_pop),
    .valid_o     (w_valid),
    .count_o     (w_count),
    .head_o      (w_head)
  );

endmodule

// File: tb/tb_ift_sram_initiator.sv
// Randomized and directed bench for ift_sram_initiator.
// Reference model: queue of outstanding responses with due cycles.
module tb_ift_sram_initiator;

  localparam int W  = 64;
  localparam int AW = 8;
  localparam int MW = W / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_valid_t, req_write, req_write_t;
  logic [AW-1:0] addr, addr_t;
  logic [W-1:0]  wdata, wdata_t;
  logic [MW-1:0] wmask, wmask_t;
  logic          rsp_ready;

  logic          req_ready_o;
  logic          sram_req_o, sram_req_o_taint;
  logic          sram_write_o, sram_write_o_taint;
  logic [AW-1:0] sram_addr_o, sram_addr_o_taint;
  logic [W-1:0]  sram_wdata_o, sram_wdata_o_taint;
  logic [MW-1:0] sram_wmask_o, sram_wmask_o_taint;
  logic [W-1:0]  s_rd, s_rd_t;
  logic          rsp_valid_o, rsp_write_o;
  logic [W-1:0]  rsp_rdata_o, rsp_rdata_o_taint;

  always #5 clk = ~clk;

  ift_sram_initiator #(.Width(W), .Aw(AW), .NumTaints(1)) dut (
    .clk_i (clk), .rst_i (rst),
    .req_valid_i (req_valid), .req_valid_i_taint (req_valid_t),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write), .req_write_i_taint (req_write_t),
    .req_addr_i (addr), .req_addr_i_taint (addr_t),
    .req_wdata_i (wdata), .req_wdata_i_taint (wdata_t),
    .req_wmask_i (wmask), .req_wmask_i_taint (wmask_t),
    .sram_req_o (sram_req_o), .sram_req_o_taint (sram_req_o_taint),
    .sram_write_o (sram_write_o), .sram_write_o_taint (sram_write_o_taint),
    .sram_addr_o (sram_addr_o), .sram_addr_o_taint (sram_addr_o_taint),
    .sram_wdata_o (sram_wdata_o), .sram_wdata_o_taint (sram_wdata_o_taint),
    .sram_wmask_o (sram_wmask_o), .sram_wmask_o_taint (sram_wmask_o_taint),
    .sram_rdata_i (s_rd), .sram_rdata_i_taint (s_rd_t),
    .rsp_valid_o (rsp_valid_o), .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write_o),
    .rsp_rdata_o (rsp_rdata_o), .rsp_rdata_o_taint (rsp_rdata_o_taint)
  );

  // SRAM stub driven purely by the DUT's SRAM port
  logic [W-1:0] sm_d [256];
  logic [W-1:0] sm_t [256];
  logic         load;
  logic [W-1:0] ref_d [256];
  logic [W-1:0] ref_t [256];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        sm_d[i] = ref_d[i];
        sm_t[i] = ref_t[i];
      end
    end else if (sram_req_o) begin
      if (sram_write_o) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask_o[b]) begin
            sm_d[sram_addr_o][8*b +: 8] = sram_wdata_o[8*b +: 8];
            sm_t[sram_addr_o][8*b +: 8] = sram_wdata_o_taint[8*b +: 8];
          end
      end else begin
        s_rd   <= sm_d[sram_addr_o];
        s_rd_t <= sm_t[sram_addr_o];
      end
    end
  end

  typedef struct {
    logic         w;
    logic [W-1:0] d;
    logic [W-1:0] t;
    int           due;
  } exp_t;

  exp_t         q [$];
  logic [W-1:0] got_d [$];
  logic [W-1:0] got_t [$];
  int  n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0;
  logic last_acc;
  logic sticky_m;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Spec rules applied to the accepted request
  task automatic model_accept();
    exp_t e;
    logic ctrl;
    ctrl = (|addr_t) | req_valid_t | req_write_t | sticky_m;
    e.w   = req_write;
    e.due = cyc + 2;
    if (req_write) begin
      e.d = '0;
      e.t = ctrl ? '1 : '0;
      for (int b = 0; b < MW; b++)
        if (wmask[b]) begin
          ref_d[addr][8*b +: 8] = wdata[8*b +: 8];
          ref_t[addr][8*b +: 8] = wdata_t[8*b +: 8];
        end
`ifdef IFT_SRAM_INIT_STICKY_TAINT_EN
      if ((|addr_t) && ((|(wmask | wmask_t)) || req_write_t))
        sticky_m = 1'b1;
`endif
    end else begin
      e.d = ref_d[addr];
      e.t = ref_t[addr] | (ctrl ? '1 : '0);
    end
    q.push_back(e);
  endtask

  task automatic step();
    logic vld_e, pop_e, rdy_e, acc;
    #1;
    vld_e = !rst && q.size() > 0 && q[0].due <= cyc;
    pop_e = vld_e && rsp_ready;
    rdy_e = !rst && ((q.size() - (pop_e ? 1 : 0)) < 2);
    check("rsp_valid", rsp_valid_o, vld_e);
    check("req_ready", req_ready_o, rdy_e);
    if (vld_e) begin
      check("rsp_write", rsp_write_o, q[0].w);
      check("rsp_rdata", rsp_rdata_o, q[0].d);
      check("rsp_taint", rsp_rdata_o_taint, q[0].t);
    end else begin
      check("idle_data", {rsp_write_o, rsp_rdata_o}, '0);
      check("idle_taint", rsp_rdata_o_taint, '0);
    end
    if (rst) begin
      check("rst_sram", {sram_write_o, sram_addr_o,
                         sram_wdata_o, sram_wmask_o}, '0);
      check("rst_sram_t", {sram_req_o_taint, sram_write_o_taint,
                           sram_addr_o_taint, sram_wdata_o_taint,
                           sram_wmask_o_taint}, '0);
    end
    acc = req_valid && rdy_e;
    check("sram_req", sram_req_o, acc);
    if (acc) begin
      check("sram_ctl", {sram_write_o, sram_addr_o, sram_wmask_o},
                        {req_write, addr, wmask});
      check("sram_wdata", sram_wdata_o, wdata);
      check("sram_taints", {sram_req_o_taint, sram_write_o_taint,
                            sram_addr_o_taint, sram_wmask_o_taint},
                           {req_valid_t, req_write_t, addr_t, wmask_t});
      check("sram_wdata_t", sram_wdata_o_taint, wdata_t);
      model_accept();
    end
    if (pop_e) begin
      got_d.push_back(rsp_rdata_o);
      got_t.push_back(rsp_rdata_o_taint);
      void'(q.pop_front());
    end
    if (rst) begin
      q.delete();
      sticky_m = 1'b0;
    end
    last_acc = acc;
    n_acc += int'(acc);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    req_valid = 0; req_valid_t = 0; req_write = 0; req_write_t = 0;
    addr = 0; addr_t = 0; wdata = 0; wdata_t = 0;
    wmask = 0; wmask_t = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [AW-1:0] at);
    idle();
    req_valid = 1; addr = a; addr_t = at;
  endtask

  task automatic drain();
    idle();
    rsp_ready = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    step();
    check("drain_left", q.size(), 0);
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 256; i++) begin
      ref_d[i] = {$urandom, $urandom};
      ref_t[i] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '0;
    end
    ref_d[8'h10] = 64'hDEAD_BEEF; ref_t[8'h10] = '0;
    ref_t[8'h11] = 64'hF0;
    ref_t[8'h21] = '0;
    sticky_m = 0; last_acc = 0;
    idle();
    rsp_ready = 1; rst = 1; load = 1;
    @(negedge clk);
    step();
    load = 0;
    step();
    rst = 0;

    // Untainted read, T+2 latency
    got_d.delete(); got_t.delete();
    set_rd(8'h10, 0); step();
    idle(); step();
    #1;
    check("rd_valid_t2", rsp_valid_o, 1'b1);
    check("rd_deadbeef", rsp_rdata_o, 64'hDEAD_BEEF);
    drain();
    check("rd_taint0", got_t[0], '0);

    // Tainted address then clean read
    got_d.delete(); got_t.delete();
    set_rd(8'h10, 8'h01); step();
    set_rd(8'h11, 8'h00); step();
    drain();
    check("taddr_ones", got_t[0], {W{1'b1}});
    check("clean_stored", got_t[1], 64'hF0);

    // Backpressure: two accepted, third waits
    rsp_ready = 0;
    a0 = n_acc;
    set_rd(8'h01, 0); step();
    set_rd(8'h02, 0); step();
    set_rd(8'h03, 0); step();
    check("bp_third_blk", last_acc, 1'b0);
    check("bp_two_acc", n_acc - a0, 2);
    rsp_ready = 1;
    for (int i = 0; i < 5 && !last_acc; i++) step();
    check("bp_third_acc", last_acc, 1'b1);
    drain();

    // Streaming 8 reads
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      set_rd(AW'(8'h40 + i), 0);
      step();
    end
    check("stream_acc", n_acc - a0, 8);
    drain();

    // Reset in the cycle after issue
    set_rd(8'h05, 0); step();
    idle(); rst = 1; step();
    rst = 0;
    for (int i = 0; i < 4; i++) step();
    check("rst_no_rsp", rsp_valid_o, 1'b0);

    // Sticky taint
    got_d.delete(); got_t.delete();
    idle();
    req_valid = 1; req_write = 1; addr = 8'h20; addr_t = 8'h02;
    wmask = 8'hFF; wdata = {$urandom, $urandom};
    step();
    set_rd(8'h21, 0); step();
    drain();
`ifdef IFT_SRAM_INIT_STICKY_TAINT_EN
    check("sticky_rd", got_t[1], {W{1'b1}});
`else
    check("sticky_rd", got_t[1], '0);
`endif
    idle(); rst = 1; step(); rst = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      req_valid   = ($urandom_range(0, 2) != 0);
      req_write   = $urandom_range(0, 1) == 1;
      addr        = AW'($urandom_range(0, 15));
      addr_t      = ($urandom_range(0, 7) == 0) ?
                    AW'(1 << $urandom_range(0, 7)) : '0;
      req_valid_t = ($urandom_range(0, 15) == 0);
      req_write_t = ($urandom_range(0, 15) == 0);
      wdata       = {$urandom, $urandom};
      wdata_t     = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '0;
      wmask       = MW'($urandom);
      wmask_t     = ($urandom_range(0, 7) == 0) ? MW'($urandom) : '0;
      rsp_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
